nibble_rx_buf: RTL

Receive-side buffer for the 4-bit per-clock data stream produced by the nibble source block. It samples `in_data` on every rising `clk` edge where `in_valid` is high and stores the sample in a small FIFO. It presents the stored samples on a valid/ready output port, oldest first. It also reports fill level, a sticky overflow flag and, optionally, a saturating drop counter, so the testbench sampling path can consume the stream at its own pace.

---
 rtl/nibble_rx_buf.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nibble_rx_buf.sv
// Receive FIFO for the 4-bit nibble stream with valid/ready output, fill level and sticky overflow.
// Optional saturating drop counter enabled by defining NIBBLE_RX_DROP_CNT_EN.
module nibble_rx_buf #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
`ifdef NIBBLE_RX_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fill_e;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   fill_e            status_q;
   fill_e            status_nxt;
   logic             overflow_q;
   logic             overflow_nxt;
   logic             push;
   logic             pop;
   logic             drop;

   // Handshake decode; a full FIFO still accepts a push when a pop frees a slot.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
      pop  = (status_q != ST_EMPTY) && out_ready;
      push = in_valid && ((status_q != ST_FULL) || pop);
      drop = in_valid && !push;
   end

   // Next fill count and status classification.
   always_comb begin
      count_nxt  = count;
      status_nxt = ST_PARTIAL;
      unique case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      if (count_nxt == CNT_W'(0)) begin
         status_nxt = ST_EMPTY;
      end else if (count_nxt == CNT_W'(DEPTH)) begin
         status_nxt = ST_FULL;
      end
   end

   // A drop in the same cycle as a clear wins, so the flag stays set.
   always_comb begin
      overflow_nxt = overflow_q;
      if (drop) begin
         overflow_nxt = 1'b1;
      end else if (clr_ovf) begin
         overflow_nxt = 1'b0;
      end
   end

   // Storage, pointers and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         status_q   <= ST_EMPTY;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count      <= count_nxt;
         status_q   <= status_nxt;
         overflow_q <= overflow_nxt;
      end
   end

`ifdef NIBBLE_RX_DROP_CNT_EN
   logic [7:0] drop_q;
   logic [7:0] drop_nxt;

   // Saturating count of dropped samples; a colliding clear restarts at one.
   always_comb begin
      drop_nxt = drop_q;
      if (drop) begin
         if (clr_ovf) begin
            drop_nxt = 8'd1;
         end else if (drop_q != 8'hFF) begin
            drop_nxt = drop_q + 8'd1;
         end
      end else if (clr_ovf) begin
         drop_nxt = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= 8'd0;
      end else begin
         drop_q <= drop_nxt;
      end
   end

   assign drop_cnt = drop_q;
`endif

   assign out_valid = (status_q != ST_EMPTY);
   assign out_data  = mem[rd_ptr];
   assign level     = count;
   assign overflow  = overflow_q;

endmodule
